// File: rtl/video_src_mux.sv
// rtl/video_src_mux.sv - frame-boundary N-channel video source selector with per-channel vsync watchdog
// Optional feature macro: VIDEO_SRC_MUX_AUTO_FAILOVER_EN (auto-switch away from a channel whose vsync dies)
module video_src_mux #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 2000000,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_vsync,
    input  logic [NUM_CH-1:0]        in_de,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]          sel_req,
    input  logic                     sel_req_valid,
    output logic                     out_vsync,
    output logic                     out_de,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          sel_active,
    output logic                     switching,
    output logic                     switch_done,
    output logic                     req_err,
    output logic [NUM_CH-1:0]        ch_alive,
    output logic [15:0]              frame_cnt
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_STREAM   = 2'd0,
        ST_WAIT_END = 2'd1,
        ST_WAIT_NEW = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_tgt;
    logic [CH_W-1:0]     w_tgt_nxt;
    logic [CH_W-1:0]     w_sel_nxt;
    logic [CNT_W-1:0]    r_tmr;
    logic                w_tmr_clr;
    logic                w_tmo;
    logic                w_done;

    logic [NUM_CH-1:0]   r_vs_d;
    logic [NUM_CH-1:0]   w_rise;
    logic [CNT_W-1:0]    r_wd_cnt [NUM_CH];
    logic                r_out_vs_d;

    logic                w_ext_ok;
    logic                w_auto_v;
    logic                w_rq_v;
    logic [CH_W-1:0]     w_rq_ch;
    logic                w_blank;
    logic [DATA_W-1:0]   w_fwd_data;

    assign w_rise = in_vsync & ~r_vs_d;

    // Per-channel watchdog: a rising edge always wins over saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d   <= '0;
            ch_alive <= '0;
            for (int k = 0; k < NUM_CH; k++) r_wd_cnt[k] <= '0;
        end else begin
            r_vs_d <= in_vsync;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_rise[k]) begin
                    r_wd_cnt[k] <= '0;
                    ch_alive[k] <= 1'b1;
                end else if (r_wd_cnt[k] != TMO) begin
                    r_wd_cnt[k] <= r_wd_cnt[k] + CNT_W'(1);
                    if (r_wd_cnt[k] == TMO_M1) ch_alive[k] <= 1'b0;
                end
            end
        end
    end

    assign w_ext_ok = sel_req_valid && ({1'b0, sel_req} < NUM_CH_V);

`ifdef VIDEO_SRC_MUX_AUTO_FAILOVER_EN
    logic [NUM_CH-1:0] r_alive_d;
    logic [CH_W-1:0]   w_auto_ch;

    always_ff @(posedge clk) begin
        if (rst) r_alive_d <= '0;
        else     r_alive_d <= ch_alive;
    end

    always_comb begin
        w_auto_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_alive[k]) w_auto_ch = CH_W'(k);
        end
    end

    // External strobes (even out-of-range ones) shadow the internal request.
    assign w_auto_v = (r_state == ST_STREAM) && r_alive_d[sel_active] && !ch_alive[sel_active]
                      && (|ch_alive) && !sel_req_valid;
`else
    logic [CH_W-1:0] w_auto_ch;
    assign w_auto_ch = '0;
    assign w_auto_v  = 1'b0;
`endif

    assign w_rq_v  = sel_req_valid ? w_ext_ok : w_auto_v;
    assign w_rq_ch = sel_req_valid ? sel_req : w_auto_ch;
    assign w_tmo   = (r_tmr == TMO_M1);

    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_sel_nxt   = sel_active;
        w_tmr_clr   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_STREAM: begin
                if (w_rq_v && (w_rq_ch != sel_active)) begin
                    w_tgt_nxt   = w_rq_ch;
                    w_state_nxt = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (w_rq_v && (w_rq_ch == sel_active)) begin
                    w_state_nxt = ST_STREAM;
                end else begin
                    if (w_rq_v) w_tgt_nxt = w_rq_ch;
                    if (w_rise[sel_active] || w_tmo) w_state_nxt = ST_WAIT_NEW;
                end
            end
            ST_WAIT_NEW: begin
                if (w_rq_v && (w_rq_ch != r_tgt)) begin
                    w_tgt_nxt = w_rq_ch;
                    w_tmr_clr = 1'b1;
                end else if (w_rise[r_tgt] || w_tmo) begin
                    w_sel_nxt   = r_tgt;
                    w_state_nxt = ST_STREAM;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_STREAM;
        endcase
    end

    // Outputs follow the next state so the new channel's vsync-rise cycle is its first forwarded one.
    assign w_blank    = (w_state_nxt == ST_WAIT_NEW);
    assign w_fwd_data = in_data[int'(w_sel_nxt) * DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_STREAM;
            r_tgt       <= '0;
            r_tmr       <= '0;
            r_out_vs_d  <= 1'b0;
            sel_active  <= '0;
            switching   <= 1'b0;
            switch_done <= 1'b0;
            req_err     <= 1'b0;
            out_vsync   <= 1'b0;
            out_de      <= 1'b0;
            out_data    <= '0;
            frame_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tgt       <= w_tgt_nxt;
            if ((w_state_nxt != r_state) || w_tmr_clr) r_tmr <= '0;
            else if (r_tmr != TMO)                      r_tmr <= r_tmr + CNT_W'(1);
            sel_active  <= w_sel_nxt;
            switching   <= (w_state_nxt != ST_STREAM);
            switch_done <= w_done;
            req_err     <= sel_req_valid && !w_ext_ok;
            out_vsync   <= w_blank ? 1'b1 : in_vsync[w_sel_nxt];
            out_de      <= w_blank ? 1'b0 : in_de[w_sel_nxt];
            out_data    <= w_blank ? '0 : w_fwd_data;
            r_out_vs_d  <= out_vsync;
            frame_cnt   <= frame_cnt + 16'(out_vsync & ~r_out_vs_d);
        end
    end

endmodule

// File: tb/tb_video_src_mux.sv
// tb/tb_video_src_mux.sv - self-checking bench for video_src_mux (table vectors, directed sequences, random vs model)
module tb_video_src_mux;

    localparam int NCH = 5;
    localparam int DW  = 16;
    localparam int TMO = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    in_vsync = '0;
    logic [NCH-1:0]    in_de = '0;
    logic [NCH*DW-1:0] in_data = '0;
    logic [2:0]        sel_req = '0;
    logic              sel_req_valid = 1'b0;
    logic              out_vsync, out_de, switching, switch_done, req_err;
    logic [DW-1:0]     out_data;
    logic [2:0]        sel_active;
    logic [NCH-1:0]    ch_alive;
    logic [15:0]       frame_cnt;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    int per [NCH] = '{40, 46, 52, 58, 64};
    int ph  [NCH];
    bit run [NCH] = '{default: 1'b1};

    logic tb_blank;
    assign tb_blank = out_vsync & ~out_de & (out_data == '0);

    video_src_mux #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
        .sel_req(sel_req), .sel_req_valid(sel_req_valid),
        .out_vsync(out_vsync), .out_de(out_de), .out_data(out_data),
        .sel_active(sel_active), .switching(switching), .switch_done(switch_done),
        .req_err(req_err), .ch_alive(ch_alive), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Channel generators: 3-cycle vsync per period, de in the middle, data never zero.
    initial begin
        logic [NCH-1:0]    vs_v, de_v;
        logic [NCH*DW-1:0] d_v;
        for (int k = 0; k < NCH; k++) ph[k] = $urandom_range(0, per[k] - 1);
        forever begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) begin
                if (run[k]) begin
                    ph[k]   = (ph[k] + 1) % per[k];
                    vs_v[k] = (ph[k] < 3);
                    de_v[k] = (ph[k] >= 6) && (ph[k] < per[k] - 4);
                end else begin
                    vs_v[k] = 1'b0;
                    de_v[k] = 1'b0;
                end
                d_v[k*DW +: DW] = 16'($urandom) | 16'h0001;
            end
            in_vsync = vs_v;
            in_de    = de_v;
            in_data  = d_v;
        end
    end

    // Reference model: pending/blanking flags plus an age count per switch phase.
    int             m_cur, m_tgt, m_age, e_sel, e_fc;
    bit             m_pend, m_blank, m_ovprev;
    bit             e_vs, e_de, e_sw, e_done, e_err;
    logic [DW-1:0]  e_data;
    logic [NCH-1:0] m_vprev, m_alive, m_alive_prev;
    int             m_wd [NCH];

    always @(posedge clk) begin : ref_model
        logic [NCH-1:0] rise;
        bit req, expired;
        int rch;
        if (rst) begin
            m_cur = 0; m_tgt = 0; m_age = 0; m_pend = 0; m_blank = 0; m_ovprev = 0;
            m_vprev = '0; m_alive = '0; m_alive_prev = '0;
            for (int k = 0; k < NCH; k++) m_wd[k] = 0;
            e_vs = 0; e_de = 0; e_data = '0; e_sel = 0; e_sw = 0; e_done = 0; e_err = 0; e_fc = 0;
        end else begin
            rise    = in_vsync & ~m_vprev;
            m_vprev = in_vsync;
            expired = (m_age + 1 >= TMO);
            e_err   = sel_req_valid && (sel_req >= NCH);
            req     = sel_req_valid && (sel_req < NCH);
            rch     = sel_req;
`ifdef VIDEO_SRC_MUX_AUTO_FAILOVER_EN
            if (!m_pend && !sel_req_valid && m_alive_prev[m_cur] && !m_alive[m_cur] && (m_alive != '0)) begin
                req = 1;
                for (int k = NCH - 1; k >= 0; k--) if (m_alive[k]) rch = k;
            end
`endif
            e_done = 0;
            if (!m_pend) begin
                if (req && rch != m_cur) begin m_tgt = rch; m_pend = 1; m_blank = 0; m_age = 0; end
            end else if (!m_blank) begin
                if (req && rch == m_cur) begin
                    m_pend = 0; m_age = 0;
                end else begin
                    if (req) m_tgt = rch;
                    if (rise[m_cur] || expired) begin m_blank = 1; m_age = 0; end
                    else m_age++;
                end
            end else begin
                if (req && rch != m_tgt) begin
                    m_tgt = rch; m_age = 0;
                end else if (rise[m_tgt] || expired) begin
                    m_cur = m_tgt; m_pend = 0; m_blank = 0; e_done = 1; m_age = 0;
                end else m_age++;
            end
            m_alive_prev = m_alive;
            for (int k = 0; k < NCH; k++) begin
                if (rise[k]) begin
                    m_wd[k] = 0; m_alive[k] = 1'b1;
                end else begin
                    if (m_wd[k] < TMO) m_wd[k]++;
                    if (m_wd[k] == TMO) m_alive[k] = 1'b0;
                end
            end
            if (e_vs && !m_ovprev) e_fc = (e_fc + 1) % 65536;
            m_ovprev = e_vs;
            if (m_pend && m_blank) begin
                e_vs = 1; e_de = 0; e_data = '0;
            end else begin
                e_vs = in_vsync[m_cur]; e_de = in_de[m_cur]; e_data = in_data[m_cur*DW +: DW];
            end
            e_sel = m_cur;
            e_sw  = m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_model",
                {out_vsync, out_de, out_data, sel_active, switching, switch_done, req_err, ch_alive, frame_cnt},
                {e_vs, e_de, e_data, 3'(e_sel), e_sw, e_done, e_err, m_alive, 16'(e_fc)});
    end

    task automatic strobe(input logic [2:0] ch);
        sel_req = ch;
        sel_req_valid = 1'b1;
        @(negedge clk);
        sel_req_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0] req;
        logic       exp_err;
        logic [2:0] exp_sel;
        logic       exp_sw;
    } vec_t;

    initial begin
        vec_t       vecs [4];
        logic [15:0] d;
        logic       de0;
        int         ndone, nblank, fc0, k;
        bit         done_vs, ok;

        vecs[0] = '{3'd5, 1'b1, 3'd0, 1'b0};
        vecs[1] = '{3'd7, 1'b1, 3'd0, 1'b0};
        vecs[2] = '{3'd0, 1'b0, 3'd0, 1'b0};
        vecs[3] = '{3'd6, 1'b1, 3'd0, 1'b0};

        @(posedge clk); #1; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_vsync", out_vsync, 0);
        chk("rst_sel", sel_active, 0);
        chk("rst_alive", ch_alive, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_switching", switching, 0);
        @(negedge clk); rst = 1'b0;

        repeat (150) @(negedge clk);
        chk("alive_all", ch_alive, 5'b11111);
        chk("sel_ch0", sel_active, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); d = in_data[15:0]; de0 = in_de[0];
            @(negedge clk);
            chk("fwd_data", out_data, d);
            chk("fwd_de", out_de, de0);
        end

        for (int i = 0; i < 4; i++) begin
            strobe(vecs[i].req);
            chk("vec_req_err", req_err, vecs[i].exp_err);
            chk("vec_sel", sel_active, vecs[i].exp_sel);
            chk("vec_switching", switching, vecs[i].exp_sw);
            @(negedge clk);
            chk("vec_err_pulse", req_err, 0);
        end

        // Switch 0 -> 2 requested mid-frame of ch0.
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin @(posedge clk); if (ph[0] == 20) ok = 1; end
        @(negedge clk);
        strobe(3'd2);
        chk("b_switching", switching, 1);
        chk("b_sel_hold", sel_active, 0);
        ndone = 0; nblank = 0; done_vs = 0;
        for (int i = 0; i < 300; i++) begin
            if (switch_done) begin ndone = 1; done_vs = out_vsync; break; end
            if (tb_blank) nblank++;
            @(negedge clk);
        end
        chk("b_done_seen", ndone, 1);
        chk("b_done_vsync", done_vs, 1);
        chk("b_sel", sel_active, 2);
        chk("b_blanked", (nblank > 0), 1);
        @(negedge clk);
        chk("b_done_once", switch_done, 0);
        chk("b_switching_off", switching, 0);

        // Dead target: WAIT_NEW must expire after exactly TMO cycles.
        run[3] = 0;
        repeat (250) @(negedge clk);
        chk("c_alive3_dead", ch_alive[3], 0);
        strobe(3'd3);
        ndone = 0; nblank = 0;
        for (int i = 0; i < 400; i++) begin
            if (switch_done) begin ndone = 1; break; end
            if (tb_blank) nblank++;
            @(negedge clk);
        end
        chk("c_done_seen", ndone, 1);
        chk("c_wait_new_len", nblank, TMO);
        chk("c_sel", sel_active, 3);
        chk("c_alive3", ch_alive[3], 0);

        // Cancel: request another channel, then the current one during WAIT_END.
        @(negedge clk);
        fc0 = frame_cnt;
        strobe(3'd2);
        chk("d_switching", switching, 1);
        strobe(3'd3);
        chk("d_cancelled", switching, 0);
        chk("d_sel", sel_active, 3);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (switch_done) ndone++; end
        chk("d_no_done", ndone, 0);
        chk("d_fcnt_cont", frame_cnt, fc0);
        run[3] = 1;
        repeat (120) @(negedge clk);
        strobe(3'd0);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); if (switch_done) ok = 1; end
        chk("d_back_done", ok, 1);
        chk("d_back_sel", sel_active, 0);

        // Reset during a switch discards the pending target.
        strobe(3'd1);
        chk("e_switching", switching, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("e_rst_sel", sel_active, 0);
        chk("e_rst_switching", switching, 0);
        repeat (10) @(negedge clk);
        chk("e_stay_sel", sel_active, 0);
        chk("e_stay_idle", switching, 0);
        repeat (150) @(negedge clk);

        // Active channel dies.
        run[0] = 0;
        ndone = 0;
        for (int i = 0; i < 500; i++) begin @(negedge clk); if (switch_done) ndone++; end
        chk("f_alive0_dead", ch_alive[0], 0);
`ifdef VIDEO_SRC_MUX_AUTO_FAILOVER_EN
        chk("f_auto_done", ndone, 1);
        chk("f_auto_sel", sel_active, 1);
`else
        chk("f_no_done", ndone, 0);
        chk("f_sel_kept", sel_active, 0);
        chk("f_idle", switching, 0);
`endif
        run[0] = 1;
        repeat (150) @(negedge clk);

        // Random requests and channel outages against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) begin k = $urandom_range(0, NCH - 1); run[k] = !run[k]; end
            if ($urandom_range(0, 29) == 0) begin
                sel_req = 3'($urandom_range(0, 7));
                sel_req_valid = 1'b1;
            end else begin
                sel_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        sel_req_valid = 1'b0;
        for (int i = 0; i < NCH; i++) run[i] = 1;
        repeat (300) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
